memory_access_controller: RTL and testbench
===========================================

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 The module SHALL have parameter SIZE, default 16, meaning data word width.
REQ-002 The module SHALL have parameter MAR_SIZE, default 8, meaning address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  host transaction request; sampled only in IDLE.
REQ-006 we  input  1  1 = burst write, 0 = burst read; sampled with req.
REQ-007 addr  input  MAR_SIZE  burst start address; sampled with req.
REQ-008 len  input  4  burst length minus one, so beats = len+1 (1..16); sampled with req.
REQ-009 wdata  input  SIZE  write data for the current beat.
REQ-010 ready  output  1  high only in IDLE; a request is accepted on an edge where req & ready.
REQ-011 wdata_take  output  1  high in a write ACCESS cycle; host advances wdata after this edge.
REQ-012 rdata  output  SIZE  registered read data.
REQ-013 rvalid  output  1  one-cycle pulse; rdata holds a new word.
REQ-014 done  output  1  one-cycle pulse at burst end.
REQ-015 mem_address  output  MAR_SIZE  address to the RAM address register.
REQ-016 mem_set_address  output  1  RAM address-register load strobe.
REQ-017 mem_set  output  1  RAM write strobe.
REQ-018 mem_enable  output  1  RAM read-enable.
REQ-019 mem_data_in  output  SIZE  RAM write data.
REQ-020 mem_data_out  input  SIZE  RAM read data; valid while mem_enable is high.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, ACCESS and DONE.
REQ-022 IDLE: ready=1; on req, latch we, addr into cur_addr and len into remaining, then go to LOAD.
REQ-023 LOAD: mem_address=cur_addr, mem_set_address=1, then go to ACCESS.
REQ-024 ACCESS, write: mem_set=1, mem_data_in=wdata, wdata_take=1.
REQ-025 ACCESS, read: mem_enable=1; rdata<=mem_data_out at the closing edge; rvalid=1 in the following cycle.
REQ-026 ACCESS exit: if remaining==0, go to DONE; else remaining decrements, cur_addr increments, and the FSM returns to LOAD.
REQ-027 Address increment SHALL wrap modulo 2^MAR_SIZE (8'hFF -> 8'h00) with no error.
REQ-028 DONE: done=1 for exactly one cycle, then go to IDLE; ready returns the next cycle.
REQ-029 Latency: with the accept edge as cycle 0, beat k (0-based) occupies LOAD at cycle 2k+1 and ACCESS at cycle 2k+2; DONE occurs at cycle 2(len+1)+1.
REQ-030 req while not in IDLE SHALL be ignored; inputs are not re-sampled mid-burst.
REQ-031 At most one of mem_set_address, mem_set and mem_enable SHALL be high in any cycle.
REQ-032 All three RAM strobes SHALL be 0 in IDLE and DONE.
REQ-033 mem_address SHALL equal cur_addr in all states.
REQ-034 mem_data_in SHALL be 0 outside a write ACCESS.
REQ-035 rdata SHALL hold its value between rvalid pulses.
REQ-036 Strobe, ready, wdata_take and done outputs SHALL decode only from registered state and direction, with no combinational path from req.

Reset
REQ-037 While reset is high: state=IDLE; cur_addr, remaining and rdata are 0; rvalid, done, wdata_take and all RAM strobes are 0; ready=1.
REQ-038 Reset asserted mid-burst SHALL abort the burst immediately, with no further strobes and no done.
REQ-039 After reset deasserts, the first edge with req SHALL be accepted.

Verification
REQ-040 Single write (we=1, addr=8'h12, len=0, wdata=16'hBEEF): mem_set_address at cycle 1 with mem_address=8'h12; mem_set at cycle 2 with mem_data_in=16'hBEEF; done at cycle 3.
REQ-041 Single read of 8'h12 against a RAM model holding 16'hBEEF: mem_enable at cycle 2; rvalid at cycle 3 with rdata=16'hBEEF, coincident with done.
REQ-042 Burst write (addr=8'hFE, len=3, data 1..4): writes go to FE, FF, 00, 01 in order, confirming wrap; 4 wdata_take pulses; done at cycle 9.
REQ-043 Burst read of 16 beats (len=15) after REQ-042: 16 rvalid pulses; the rvalid pulses for addresses FE, FF, 00, 01 carry data 1..4; done at cycle 33.
REQ-044 req held high throughout a burst, plus reset pulsed at cycle 4 of a len=3 write: only one burst is accepted before the reset; the aborted burst produces no strobes after reset and no done; ready=1 during reset; a new req is accepted on the first edge after release.
REQ-045 Every cycle of every test: an assertion SHALL check the strobe mutual exclusion of REQ-031.

Source files
------------

// File: rtl/memory_access_controller.sv
// Burst read/write sequencer in front of a RAM with a separate address register.
// Each beat is a LOAD (address strobe) followed by an ACCESS (write or read strobe).
module memory_access_controller #(
  parameter int SIZE     = 16,
  parameter int MAR_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [MAR_SIZE-1:0] addr,
  input  logic [3:0]          len,
  input  logic [SIZE-1:0]     wdata,
  output logic                ready,
  output logic                wdata_take,
  output logic [SIZE-1:0]     rdata,
  output logic                rvalid,
  output logic                done,
  output logic [MAR_SIZE-1:0] mem_address,
  output logic                mem_set_address,
  output logic                mem_set,
  output logic                mem_enable,
  output logic [SIZE-1:0]     mem_data_in,
  input  logic [SIZE-1:0]     mem_data_out
);

  // state  | meaning
  // IDLE   | ready for a request; burst parameters latched on req
  // LOAD   | drive cur_addr into the RAM address register
  // ACCESS | write strobe (we) or read enable (!we) for the current beat
  // DONE   | one-cycle done pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, DONE} state_t;

  state_t              state_q;
  logic                we_q;
  logic [MAR_SIZE-1:0] cur_addr_q;
  logic [3:0]          remaining_q;
  logic [SIZE-1:0]     rdata_q;
  logic                rvalid_q;
  logic                done_q;
  logic                ready_q;
  logic                wdata_take_q;
  logic                mem_set_address_q;
  logic                mem_set_q;
  logic                mem_enable_q;

  // Outputs are registered alongside the state, so req never reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      we_q              <= 1'b0;
      cur_addr_q        <= '0;
      remaining_q       <= '0;
      rdata_q           <= '0;
      rvalid_q          <= 1'b0;
      done_q            <= 1'b0;
      ready_q           <= 1'b1;
      wdata_take_q      <= 1'b0;
      mem_set_address_q <= 1'b0;
      mem_set_q         <= 1'b0;
      mem_enable_q      <= 1'b0;
    end else begin
      rvalid_q          <= 1'b0;
      done_q            <= 1'b0;
      ready_q           <= 1'b0;
      wdata_take_q      <= 1'b0;
      mem_set_address_q <= 1'b0;
      mem_set_q         <= 1'b0;
      mem_enable_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q              <= we;
            cur_addr_q        <= addr;
            remaining_q       <= len;
            mem_set_address_q <= 1'b1;
            state_q           <= LOAD;
          end else begin
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= ACCESS;
          if (we_q) begin
            mem_set_q    <= 1'b1;
            wdata_take_q <= 1'b1;
          end else begin
            mem_enable_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q  <= mem_data_out;
            rvalid_q <= 1'b1;
          end
          if (remaining_q == 4'd0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            remaining_q       <= remaining_q - 4'd1;
            cur_addr_q        <= cur_addr_q + MAR_SIZE'(1);
            mem_set_address_q <= 1'b1;
            state_q           <= LOAD;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready           = ready_q;
  assign wdata_take      = wdata_take_q;
  assign rdata           = rdata_q;
  assign rvalid          = rvalid_q;
  assign done            = done_q;
  assign mem_address     = cur_addr_q;
  assign mem_set_address = mem_set_address_q;
  assign mem_set         = mem_set_q;
  assign mem_enable      = mem_enable_q;
  // wdata is live from the host, so it is gated rather than registered.
  assign mem_data_in     = mem_set_q ? wdata : SIZE'(0);

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller: table of bursts checked cycle by cycle
// against a latency model, plus reset-abort and reset-state sequences.
module tb_memory_access_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [3:0]  len;
  logic [15:0] wdata;
  logic        ready;
  logic        wdata_take;
  logic [15:0] rdata;
  logic        rvalid;
  logic        done;
  logic [7:0]  mem_address;
  logic        mem_set_address;
  logic        mem_set;
  logic        mem_enable;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  memory_access_controller #(.SIZE(16), .MAR_SIZE(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .ready(ready), .wdata_take(wdata_take), .rdata(rdata),
    .rvalid(rvalid), .done(done), .mem_address(mem_address),
    .mem_set_address(mem_set_address), .mem_set(mem_set), .mem_enable(mem_enable),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM model: address register plus array, read data only meaningful while enabled
  logic        ram_init;
  logic [7:0]  ram_ar;
  logic [15:0] ram [256];
  int          ram_writes = 0;

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, ~a};
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(8'(i));
      ram_ar <= 8'h00;
    end else begin
      if (mem_set_address) ram_ar <= mem_address;
      if (mem_set) begin
        ram[ram_ar] <= mem_data_in;
        ram_writes  <= ram_writes + 1;
      end
    end
  end

  assign mem_data_out = mem_enable ? ram[ram_ar] : 16'hDEAD;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [15:0] exp_mem [256];

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next falling edge; strobe exclusion checked every cycle.
  task automatic tick();
    @(negedge clk);
    #1;
    n_tests++;
    if ($countones({mem_set_address, mem_set, mem_enable}) > 1) begin
      n_fail++;
      $display("FAIL strobe_excl: got %b expected at most one set at %0t",
               {mem_set_address, mem_set, mem_enable}, $time);
    end
    if (done) done_cnt++;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [15:0] data0;
  } vec_t;

  vec_t vecs [6];

  task automatic run_burst(input vec_t v);
    int          L;
    int          k;
    int          w0;
    logic        in_beat, is_load, is_acc;
    logic [7:0]  ea;
    L  = int'(v.len);
    w0 = ram_writes;
    chkb("ready_before", ready, 1'b1);
    req   = 1'b1;
    we    = v.we;
    addr  = v.addr;
    len   = v.len;
    wdata = v.data0;
    tick();
    req  = 1'b0;
    we   = ~v.we;
    addr = ~v.addr;
    len  = ~v.len;
    for (int c = 1; c <= 2 * L + 3; c++) begin
      if (c > 1) tick();
      k       = (c - 1) / 2;
      in_beat = (c <= 2 * L + 2);
      is_load = in_beat && (c % 2 == 1);
      is_acc  = in_beat && (c % 2 == 0);
      ea      = in_beat ? v.addr + 8'(k) : v.addr + 8'(L);
      if (in_beat) wdata = v.data0 + 16'(k);
      #1;
      chkb("ready", ready, 1'b0);
      chkw("mem_address", 16'(mem_address), 16'(ea));
      chkb("mem_set_address", mem_set_address, is_load);
      chkb("mem_set", mem_set, is_acc && v.we);
      chkb("wdata_take", wdata_take, is_acc && v.we);
      chkb("mem_enable", mem_enable, is_acc && !v.we);
      chkw("mem_data_in", mem_data_in, (is_acc && v.we) ? v.data0 + 16'(k) : 16'h0);
      chkb("done", done, c == 2 * L + 3);
      chkb("rvalid", rvalid, !v.we && (c % 2 == 1) && (c >= 3));
      if (!v.we && (c % 2 == 1) && (c >= 3))
        chkw("rdata", rdata, exp_mem[v.addr + 8'((c - 3) / 2)]);
      if (!v.we && (c % 2 == 0) && (c > 3))
        chkw("rdata_hold", rdata, exp_mem[v.addr + 8'((c - 4) / 2)]);
      if (is_acc && v.we) exp_mem[ea] = v.data0 + 16'(k);
    end
    tick();
    chkb("ready_after", ready, 1'b1);
    chkb("done_after", done, 1'b0);
    chkw("write_count", 16'(ram_writes - w0), v.we ? 16'(L + 1) : 16'h0);
    if (!v.we) chkw("rdata_hold_idle", rdata, exp_mem[v.addr + 8'(L)]);
  endtask

  initial begin
    int done_at_reset;
    int writes_at_reset;
    bit seen;

    vecs[0] = '{we: 1'b1, addr: 8'h12, len: 4'd0,  data0: 16'hBEEF};
    vecs[1] = '{we: 1'b0, addr: 8'h12, len: 4'd0,  data0: 16'h0000};
    vecs[2] = '{we: 1'b1, addr: 8'hFE, len: 4'd3,  data0: 16'h0001};
    vecs[3] = '{we: 1'b0, addr: 8'hFC, len: 4'd15, data0: 16'h0000};
    vecs[4] = '{we: 1'b1, addr: 8'h7F, len: 4'd1,  data0: 16'h1234};
    vecs[5] = '{we: 1'b0, addr: 8'h7E, len: 4'd3,  data0: 16'h0000};
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(8'(i));

    reset    = 1'b1;
    ram_init = 1'b1;
    req      = 1'b0;
    we       = 1'b0;
    addr     = 8'h00;
    len      = 4'd0;
    wdata    = 16'h0;
    tick();
    tick();
    chkb("rst_ready", ready, 1'b1);
    chkb("rst_done", done, 1'b0);
    chkb("rst_rvalid", rvalid, 1'b0);
    chkb("rst_wdata_take", wdata_take, 1'b0);
    chkw("rst_strobes", 16'({mem_set_address, mem_set, mem_enable}), 16'h0);
    chkw("rst_rdata", rdata, 16'h0);
    chkw("rst_mem_address", 16'(mem_address), 16'h0);
    chkw("rst_mem_data_in", mem_data_in, 16'h0);
    ram_init = 1'b0;
    reset    = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // req held high across a write burst, reset pulsed in cycle 4
    req   = 1'b1;
    we    = 1'b1;
    addr  = 8'h40;
    len   = 4'd3;
    wdata = 16'h1111;
    tick();
    chkb("hold_c1_load", mem_set_address, 1'b1);
    chkw("hold_c1_addr", 16'(mem_address), 16'h0040);
    addr = 8'h50;
    tick();
    chkb("hold_c2_set", mem_set, 1'b1);
    chkw("hold_c2_data", mem_data_in, 16'h1111);
    exp_mem[8'h40] = 16'h1111;
    tick();
    chkb("hold_c3_load", mem_set_address, 1'b1);
    chkw("hold_c3_addr", 16'(mem_address), 16'h0041);
    chkb("hold_c3_ready", ready, 1'b0);
    tick();
    chkb("hold_c4_set", mem_set, 1'b1);
    reset = 1'b1;
    #1;
    done_at_reset   = done_cnt;
    writes_at_reset = ram_writes;
    chkb("abort_ready", ready, 1'b1);
    chkw("abort_strobes", 16'({mem_set_address, mem_set, mem_enable}), 16'h0);
    chkb("abort_wdata_take", wdata_take, 1'b0);
    chkb("abort_done", done, 1'b0);
    chkb("abort_rvalid", rvalid, 1'b0);
    chkw("abort_rdata", rdata, 16'h0);
    chkw("abort_addr", 16'(mem_address), 16'h0);
    tick();
    chkb("abort_ready2", ready, 1'b1);
    chkw("abort_no_write", 16'(ram_writes - writes_at_reset), 16'h0);
    chkw("abort_no_done", 16'(done_cnt - done_at_reset), 16'h0);
    reset = 1'b0;
    tick();
    chkb("reaccept_load", mem_set_address, 1'b1);
    chkw("reaccept_addr", 16'(mem_address), 16'h0050);
    chkb("reaccept_ready", ready, 1'b0);
    req  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chkb("reaccept_done_seen", seen, 1'b1);
    chkw("reaccept_done_count", 16'(done_cnt - done_at_reset), 16'h1);
    chkw("reaccept_writes", 16'(ram_writes - writes_at_reset), 16'h4);
    for (int i = 0; i < 4; i++) exp_mem[8'h50 + 8'(i)] = 16'h1111;
    tick();
    chkb("reaccept_ready_back", ready, 1'b1);

    run_burst('{we: 1'b0, addr: 8'h3F, len: 4'd2, data0: 16'h0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
